// File: rtl/cache_data_ctrl_if.sv
// Request/response bundle between the cache control side, the refill unit and the data banks.
// Latency: n/a (wires only); grants are combinational, load data arrives one cycle after grant.
// Backpressure: requesters hold req/addr until granted; refill beats wait on rf_ready.
interface cache_data_ctrl_if #(
  parameter int INDEX_AW   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // load port
  logic                           rd_req;
  logic [INDEX_AW-1:0]            rd_index;
  logic [1:0]                     rd_offset;
  logic                           rd_gnt;
  logic                           rd_valid;
  logic [DATA_WIDTH-1:0]          rd_data;
  // store port
  logic                           wr_req;
  logic [INDEX_AW-1:0]            wr_index;
  logic [1:0]                     wr_offset;
  logic [STRB_W-1:0]              wr_strb;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           wr_gnt;
  // refill port
  logic                           rf_start;
  logic [INDEX_AW-1:0]            rf_index;
  logic                           rf_valid;
  logic [DATA_WIDTH-1:0]          rf_data;
  logic                           rf_ready;
  logic                           rf_done;
  logic                           busy;
  // bank array side
  logic [INDEX_AW-1:0]            bank_index;
  logic [STRB_W*BANK_NUM-1:0]     bank_wr_en;
  logic [DATA_WIDTH*BANK_NUM-1:0] bank_wr_data;
  logic [DATA_WIDTH*BANK_NUM-1:0] bank_rd_data;

  // sequencer view
  modport slave (
    input  rd_req, rd_index, rd_offset,
    output rd_gnt, rd_valid, rd_data,
    input  wr_req, wr_index, wr_offset, wr_strb, wr_data,
    output wr_gnt,
    input  rf_start, rf_index, rf_valid, rf_data,
    output rf_ready, rf_done, busy,
    output bank_index, bank_wr_en, bank_wr_data,
    input  bank_rd_data
  );

  // environment view (cache FSM, refill unit and bank array together)
  modport master (
    output rd_req, rd_index, rd_offset,
    input  rd_gnt, rd_valid, rd_data,
    output wr_req, wr_index, wr_offset, wr_strb, wr_data,
    input  wr_gnt,
    output rf_start, rf_index, rf_valid, rf_data,
    input  rf_ready, rf_done, busy,
    input  bank_index, bank_wr_en, bank_wr_data,
    output bank_rd_data
  );
endinterface

// File: rtl/cache_data_ctrl.sv
// Access sequencer for one data-array way: one of refill beat / byte-masked store / load per cycle.
// Latency: store written at grant edge; load data one cycle after grant; rf_done one cycle after beat 3.
// Backpressure: grants are combinational and withheld during refill; refill beats stall on rf_valid=0.
module cache_data_ctrl #(
  parameter int INDEX_AW   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4
) (
  input logic              clk,
  input logic              rst,
  cache_data_ctrl_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                         state_q, state_d;
  logic [OFF_W-1:0]               beat_cnt_q, beat_cnt_d;
  logic [INDEX_AW-1:0]            rf_idx_q, rf_idx_d;
  logic                           rf_done_q, rf_done_d;
  logic                           rd_vld_q;
  logic [OFF_W-1:0]               rd_off_q;
  logic [DATA_WIDTH-1:0]          rd_hold_q;
  logic [DATA_WIDTH-1:0]          rd_sel;

  logic                           rd_gnt, wr_gnt, rf_ready, busy;
  logic [INDEX_AW-1:0]            bank_index;
  logic [STRB_W*BANK_NUM-1:0]     wr_en;
  logic [DATA_WIDTH*BANK_NUM-1:0] wr_data;

  // next-state and per-cycle bank command; refill > store > load in IDLE
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rf_idx_d   = rf_idx_q;
    rf_done_d  = 1'b0;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    rf_ready   = 1'b0;
    busy       = 1'b0;
    bank_index = bus.rd_index;
    wr_en      = '0;
    wr_data    = {BANK_NUM{bus.wr_data}};
    case (state_q)
      IDLE: begin
        if (bus.rf_start) begin
          rf_idx_d   = bus.rf_index;
          beat_cnt_d = '0;
          state_d    = REFILL;
        end else if (bus.wr_req) begin
          wr_gnt     = 1'b1;
          bank_index = bus.wr_index;
          for (int k = 0; k < BANK_NUM; k++) begin
            if (bus.wr_offset == OFF_W'(k)) wr_en[k*STRB_W +: STRB_W] = bus.wr_strb;
          end
        end else if (bus.rd_req) begin
          rd_gnt     = 1'b1;
          bank_index = bus.rd_index;
        end
      end
      REFILL: begin
        busy       = 1'b1;
        rf_ready   = 1'b1;
        bank_index = rf_idx_q;
        wr_data    = {BANK_NUM{bus.rf_data}};
        if (bus.rf_valid) begin
          for (int k = 0; k < BANK_NUM; k++) begin
            if (beat_cnt_q == OFF_W'(k)) wr_en[k*STRB_W +: STRB_W] = '1;
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == OFF_W'(BANK_NUM - 1)) begin
            rf_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pick the bank word addressed by the load granted last cycle
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      if (rd_off_q == OFF_W'(k)) rd_sel = bus.bank_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM and refill bookkeeping registers; reset aborts any refill silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rf_idx_q   <= '0;
      rf_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rf_idx_q   <= rf_idx_d;
      rf_done_q  <= rf_done_d;
    end
  end

  // load return pipeline; last returned word is held while no load is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_off_q  <= '0;
      rd_hold_q <= '0;
    end else begin
      rd_vld_q <= rd_gnt;
      if (rd_gnt)   rd_off_q  <= bus.rd_offset;
      if (rd_vld_q) rd_hold_q <= rd_sel;
    end
  end

  assign bus.rd_gnt       = rd_gnt;
  assign bus.wr_gnt       = wr_gnt;
  assign bus.rf_ready     = rf_ready;
  assign bus.busy         = busy;
  assign bus.rf_done      = rf_done_q;
  assign bus.rd_valid     = rd_vld_q;
  assign bus.rd_data      = rd_vld_q ? rd_sel : rd_hold_q;
  assign bus.bank_index   = bank_index;
  assign bus.bank_wr_en   = wr_en;
  assign bus.bank_wr_data = wr_data;
endmodule

// File: tb/tb_cache_data_ctrl.sv
// Bench for cache_data_ctrl: bank RAM model, word-level reference memory, load/done scoreboard.
// Latency: expects load data one cycle after grant and rf_done one cycle after the last beat.
// Backpressure: requests are held until granted, with a bounded wait per request.
module tb_cache_data_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_data_ctrl_if #(.INDEX_AW(AW), .DATA_WIDTH(DW), .BANK_NUM(NB)) bus ();

  cache_data_ctrl #(.INDEX_AW(AW), .DATA_WIDTH(DW), .BANK_NUM(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // bank array: 4 banks of byte-writable 1-cycle synchronous RAM, read-before-write
  logic [DW-1:0] ram [NB][256];
  logic [DW-1:0] ram_q [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_clr) begin
        for (int a = 0; a < 256; a++) ram[b][a] <= '0;
      end else begin
        ram_q[b] <= ram[b][bus.bank_index];
        for (int by = 0; by < 4; by++) begin
          if (bus.bank_wr_en[b*4+by])
            ram[b][bus.bank_index][by*8 +: 8] <= bus.bank_wr_data[b*DW+by*8 +: 8];
        end
      end
    end
  end
  assign bus.bank_rd_data = {ram_q[3], ram_q[2], ram_q[1], ram_q[0]};

  // reference contents: one 32-bit word per (line, bank)
  logic [31:0] ref_mem [256][4];

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      done_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: pops expected load returns and done pulses whenever the DUT presents them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_data", bus.rd_data, e.data);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        check("rd_missing", 0, 1);
        void'(rd_q.pop_front());
      end
      if (bus.rf_done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [7:0] idx, input logic [1:0] off, input logic [3:0] strb,
                          input logic [31:0] data, output int gcyc);
    bit got = 0;
    gcyc = -1;
    bus.wr_req = 1'b1; bus.wr_index = idx; bus.wr_offset = off;
    bus.wr_strb = strb; bus.wr_data = data;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.wr_gnt) begin
        got  = 1;
        gcyc = cyc;
        check("store_wen", bus.bank_wr_en, 16'(strb) << (4 * off));
        check("store_idx", bus.bank_index, idx);
        for (int by = 0; by < 4; by++)
          if (strb[by]) ref_mem[idx][off][by*8 +: 8] = data[by*8 +: 8];
      end
      step();
    end
    bus.wr_req = 1'b0;
    if (!got) check("store_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [7:0] idx, input logic [1:0] off, output int gcyc);
    bit got = 0;
    gcyc = -1;
    bus.rd_req = 1'b1; bus.rd_index = idx; bus.rd_offset = off;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.rd_gnt) begin
        got  = 1;
        gcyc = cyc;
        check("load_wen", bus.bank_wr_en, 16'h0);
        rd_q.push_back('{cyc: cyc + 1, data: ref_mem[idx][off]});
      end
      step();
    end
    bus.rd_req = 1'b0;
    if (!got) check("load_timeout", 0, 1);
  endtask

  // refill of nbeats beats (4 = full line); one idle beat slot inserted after beat 'gap'
  task automatic do_refill(input logic [7:0] idx, input logic [31:0] d [4], input int gap,
                           input int nbeats, output int dcyc);
    dcyc = -1;
    bus.rf_start = 1'b1; bus.rf_index = idx; bus.rf_valid = 1'b0;
    @(negedge clk);
    check("rf_start_gnt", {bus.rd_gnt, bus.wr_gnt}, 2'b00);
    check("rf_start_wen", bus.bank_wr_en, 16'h0);
    step();
    bus.rf_start = 1'b0;
    bus.rf_index = ~idx;
    for (int k = 0; k < nbeats; k++) begin
      bus.rf_valid = 1'b1; bus.rf_data = d[k];
      @(negedge clk);
      check("rf_status", {bus.busy, bus.rf_ready, bus.rd_gnt, bus.wr_gnt}, 4'b1100);
      check("rf_wen", bus.bank_wr_en, 16'hF << (4 * k));
      check("rf_idx", bus.bank_index, idx);
      ref_mem[idx][k] = d[k];
      if (k == 3) begin
        dcyc = cyc + 1;
        done_q.push_back(cyc + 1);
      end
      step();
      if (k == gap && k < nbeats - 1) begin
        bus.rf_valid = 1'b0;
        @(negedge clk);
        check("rf_stall_wen", bus.bank_wr_en, 16'h0);
        step();
      end
    end
    bus.rf_valid = 1'b0;
  endtask

  initial begin
    int g0, g1, g2;
    logic [31:0] d [4];

    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 4; b++) ref_mem[a][b] = '0;
    rst = 1'b1; ram_clr = 1'b1;
    bus.rd_req = 1'b0; bus.rd_index = '0; bus.rd_offset = '0;
    bus.wr_req = 1'b0; bus.wr_index = '0; bus.wr_offset = '0; bus.wr_strb = '0; bus.wr_data = '0;
    bus.rf_start = 1'b0; bus.rf_index = '0; bus.rf_valid = 1'b0; bus.rf_data = '0;

    // reset state
    step(); step();
    @(negedge clk);
    check("rst_out", {bus.rd_valid, bus.rf_done, bus.busy, bus.rf_ready}, 4'b0000);
    check("rst_wen", bus.bank_wr_en, 16'h0);
    check("rst_rdata", bus.rd_data, 32'h0);
    step();
    rst = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    check("post_rst", {bus.rd_gnt, bus.wr_gnt, bus.busy, bus.rf_ready, bus.rf_done}, 5'b0);
    step();

    // byte-masked store then load of the same word
    do_store(8'h12, 2'd2, 4'b0101, 32'hAABBCCDD, g0);
    do_load(8'h12, 2'd2, g1);
    check("wr_then_rd", g1, g0 + 1);
    step();
    @(negedge clk);
    check("rd_hold", {bus.rd_valid, bus.rd_data}, {1'b0, 32'h00BB00DD});
    step();

    // refill with one stall slot after beat 1, then read the line back
    d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_refill(8'h40, d, 1, 4, g0);
    for (int k = 0; k < 4; k++) do_load(8'h40, 2'(k), g1);
    step();

    // simultaneous refill / store / load: refill first, then store, then load
    d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    fork
      do_refill(8'h21, d, -1, 4, g0);
      do_store(8'h21, 2'd1, 4'b1100, 32'h5566_7788, g1);
      do_load(8'h21, 2'd1, g2);
    join
    check("prio_store_after_done", g1, g0);
    check("prio_load_after_store", g2, g1 + 1);
    step();

    // reset after beat 2 aborts the refill without a done pulse
    d = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    do_refill(8'h55, d, -1, 3, g0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_status", {bus.busy, bus.rf_ready, bus.rf_done}, 3'b000);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_after", {bus.busy, bus.rf_ready, bus.rf_done}, 3'b000);
    step();
    d = '{32'h0F0F0F0F, 32'h1E1E1E1E, 32'h2D2D2D2D, 32'h3C3C3C3C};
    do_refill(8'h55, d, 2, 4, g0);
    for (int k = 0; k < 4; k++) do_load(8'h55, 2'(k), g1);

    // random mix over a small index set to get plenty of overlap
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [7:0] idx;
      op  = $urandom_range(0, 9);
      idx = 8'($urandom_range(0, 7));
      if (op < 4) do_store(idx, 2'($urandom_range(0, 3)), 4'($urandom), $urandom, g0);
      else if (op < 8) do_load(idx, 2'($urandom_range(0, 3)), g0);
      else begin
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        do_refill(idx, d, $urandom_range(0, 4), 4, g0);
      end
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (4) step();
    check("rd_q_drained", rd_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
